// File: rtl/alu_ex_stage.sv
// Execute-stage ALU with valid/ready handshake on both sides and a registered result.
// Define ALU_EX_BARREL_SHIFT_EN for single-cycle shifts; otherwise shifts run 1 bit/cycle.

package alu_ex_pkg;
  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd8;
  localparam logic [3:0] ALU_SLL  = 4'd9;
  localparam logic [3:0] ALU_SRL  = 4'd10;
  localparam logic [3:0] ALU_SRA  = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } alu_state_e;
endpackage

module alu_ex_stage
  import alu_ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  alu_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        flush,
  output logic [1:0]  dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Input side accepts only in IDLE without flush; output side holds result until taken.

  alu_state_e  state, state_nxt;
  logic [31:0] result_nxt;
  logic [4:0]  cnt, cnt_nxt;
  logic [1:0]  sh_kind, sh_kind_nxt;
  logic        accept;

  assign in_ready  = rst_n & (state == ST_IDLE) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = (state == ST_HOLD);
  assign dbg_state = state;

  function automatic logic [31:0] alu_calc(input logic [3:0] op,
                                           input logic [31:0] x,
                                           input logic [31:0] y);
    logic [31:0] r;
    r = '0;
    case (op)
      ALU_ADDU: r = x + y;
      ALU_SUBU: r = x - y;
      ALU_AND:  r = x & y;
      ALU_OR:   r = x | y;
      ALU_XOR:  r = x ^ y;
      ALU_NOR:  r = ~(x | y);
      ALU_SLT:  r = {31'd0, ($signed(x) < $signed(y))};
      ALU_SLTU: r = {31'd0, (x < y)};
      ALU_LUI:  r = {y[15:0], 16'h0000};
`ifdef ALU_EX_BARREL_SHIFT_EN
      ALU_SLL:  r = y << x[4:0];
      ALU_SRL:  r = y >> x[4:0];
      ALU_SRA:  r = $unsigned($signed(y) >>> x[4:0]);
`else
      // Seed for the serial shifter; a zero amount is already the final value.
      ALU_SLL, ALU_SRL, ALU_SRA: r = y;
`endif
      default:  r = '0;
    endcase
    return r;
  endfunction

  // sh_kind: 0 = logical left, 1 = logical right, 2 = arithmetic right.
  function automatic logic [31:0] shift_step(input logic [1:0] k,
                                             input logic [31:0] v);
    logic [31:0] r;
    case (k)
      2'd0:    r = {v[30:0], 1'b0};
      2'd1:    r = {1'b0, v[31:1]};
      default: r = {v[31], v[31:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    state_nxt   = state;
    result_nxt  = result;
    cnt_nxt     = cnt;
    sh_kind_nxt = sh_kind;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          result_nxt = alu_calc(alu_op, a, b);
          state_nxt  = ST_HOLD;
`ifndef ALU_EX_BARREL_SHIFT_EN
          if (((alu_op == ALU_SLL) || (alu_op == ALU_SRL) || (alu_op == ALU_SRA)) &&
              (a[4:0] != 5'd0)) begin
            cnt_nxt     = a[4:0];
            sh_kind_nxt = (alu_op == ALU_SLL) ? 2'd0 :
                          (alu_op == ALU_SRL) ? 2'd1 : 2'd2;
            state_nxt   = ST_SHIFT;
          end
`endif
        end
      end
      ST_SHIFT: begin
        result_nxt = shift_step(sh_kind, result);
        cnt_nxt    = cnt - 5'd1;
        // The last step lands directly in HOLD so latency is amount + 1.
        if (cnt == 5'd1) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      result  <= '0;
      cnt     <= '0;
      sh_kind <= '0;
    end else begin
      state   <= state_nxt;
      result  <= result_nxt;
      cnt     <= cnt_nxt;
      sh_kind <= sh_kind_nxt;
    end
  end

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: hand-computed vectors, latency and handshake checks.
module tb_alu_ex_stage;
  import alu_ex_pkg::*;

`ifdef ALU_EX_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  alu_op = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        flush = 1'b0;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  alu_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .a(a), .b(b),
    .in_valid(in_valid), .in_ready(in_ready), .result(result),
    .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
    .dbg_state(dbg_state)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks: all enter and leave 1 time unit after a rising edge
  task automatic wait_ready(input string tag);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk({tag, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                      input string tag);
    wait_ready(tag);
    alu_op   = op;
    a        = xa;
    b        = xb;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    alu_op   = 4'($urandom_range(0, 15));
  endtask

  task automatic await_out(input string tag, input int exp_lat);
    int   lat = 0;
    logic seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        lat  = i;
      end else begin
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_result"}, result, exp_q.pop_front());
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      @(posedge clk); #1;
      chk({tag, "_valid_one_cycle"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  task automatic do_op(input logic [3:0] op, input logic [31:0] xa, input logic [31:0] xb,
                       input logic [31:0] expv, input int exp_lat, input string tag);
    exp_q.push_back(expv);
    send(op, xa, xb, tag);
    await_out(tag, exp_lat);
  endtask

  initial begin
    logic [31:0] held;
    logic        rose;

    // reset state
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

    // arithmetic / logic
    do_op(ALU_ADDU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, "addu_wrap");
    do_op(ALU_SUBU, 32'd5, 32'd7, 32'hFFFFFFFE, 1, "subu");
    do_op(ALU_AND, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 1, "and");
    do_op(ALU_OR, 32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 1, "or");
    do_op(ALU_XOR, 32'hF0F01234, 32'h0FF0FF00, 32'hFF00ED34, 1, "xor");
    do_op(ALU_NOR, 32'hF0F01234, 32'h0FF0FF00, 32'h000F00CB, 1, "nor");
    do_op(ALU_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, "slt");
    do_op(ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, "sltu");
    do_op(4'hC, 32'h1, 32'h2, 32'h00000000, 1, "undef_op");

    // shifts
    do_op(ALU_SRA, 32'd4, 32'h80000000, 32'hF8000000, BARREL ? 1 : 5, "sra4");
    do_op(ALU_SRA, 32'd3, 32'h40000000, 32'h08000000, BARREL ? 1 : 4, "sra_pos");
    do_op(ALU_SRL, 32'd8, 32'h80000000, 32'h00800000, BARREL ? 1 : 9, "srl8");
    do_op(ALU_SLL, 32'd4, 32'h0000000F, 32'h000000F0, BARREL ? 1 : 5, "sll4");
    do_op(ALU_SLL, 32'd0, 32'h00001234, 32'h00001234, 1, "sll0");

    // LUI held under backpressure for 3 cycles
    out_ready = 1'b0;
    exp_q.push_back(32'h12340000);
    send(ALU_LUI, 32'h0, 32'h00001234, "lui");
    @(negedge clk);
    chk("lui_valid", {31'd0, out_valid}, 32'd1);
    chk("lui_result", result, exp_q.pop_front());
    held = result;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("lui_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("lui_hold_stable", result, held);
      chk("lui_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("lui_pre_hs_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    chk("lui_post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("lui_post_hs_ready", {31'd0, in_ready}, 32'd1);

    // flush on cycle 3 after a long SLL
    out_ready = 1'b0;
    send(ALU_SLL, 32'd31, 32'h00000001, "sll_flush");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("flush_pre_valid", {31'd0, out_valid}, {31'd0, BARREL});
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_state_idle", {30'd0, dbg_state}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    out_ready = 1'b1;
    rose = 1'b0;
    for (int i = 0; i < 35; i++) begin
      @(negedge clk);
      if (out_valid) rose = 1'b1;
    end
    chk("flush_no_output", {31'd0, rose}, 32'd0);
    @(posedge clk); #1;
    do_op(ALU_OR, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1, "ori_after_flush");

    // reset asserted mid-shift
    send(ALU_SRL, 32'd20, 32'hDEADBEEF, "srl_reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'h0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_rel_ready", {31'd0, in_ready}, 32'd1);
    rose = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid) rose = 1'b1;
    end
    chk("midrst_no_output", {31'd0, rose}, 32'd0);
    @(posedge clk); #1;
    do_op(ALU_ADDU, 32'h00000010, 32'h00000020, 32'h00000030, 1, "addu_after_rst");

    // final report
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
